sipo_loader: RTL and testbench
==============================

Name: sipo_loader

Overview:
Serial-input, parallel-output operand loader for the EdDSA datapath. The host bus writes R_DATA_WIDTH-bit words one at a time into an N_REG-word register bank. Once every word has been written, the loader presents the full operand in parallel to the core and holds it stable until the core acknowledges consumption. It is the upstream counterpart of the result read-out stage.

Parameters:
R_DATA_WIDTH, 32, bus word width in bits
N_REG, 8, number of words in the operand (N_REG >= 2)
N_REG_BITS, $clog2(N_REG), address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
write  input  1  word write strobe, one word per cycle while high
addr  input  N_REG_BITS  word index for the current write
din  input  R_DATA_WIDTH  serial word input
clear  input  1  synchronous abort: empties the bank
ack  input  1  core has consumed the operand
dout  output  R_DATA_WIDTH*N_REG  parallel operand; word i at bits [R_DATA_WIDTH*i +: R_DATA_WIDTH]
loaded  output  N_REG  per-word written flags
dout_valid  output  1  operand complete and stable
load_done  output  1  single-cycle pulse on the FILL->HOLD transition
wr_err  output  1  sticky flag: a write was rejected

Behaviour:
- Reset (async, rst=1): dout=0, loaded=0, dout_valid=0, load_done=0, wr_err=0, state=FILL.
- States: FILL and HOLD, encoded in 1 bit.
- FILL:
  - write=1 with addr<N_REG: word[addr]<=din and loaded[addr]<=1, both taking effect the next cycle.
  - Rewriting an already-loaded word overwrites it. This is legal and does not set wr_err.
  - addr>=N_REG (only possible when N_REG is not a power of 2): write ignored, wr_err<=1.
  - When the bank becomes complete, meaning (loaded | onehot(addr) on the current write) is all ones: next cycle state=HOLD, dout_valid=1, load_done=1 for exactly one cycle.
  - Latency from the last write edge to dout_valid is 1 cycle.
- HOLD:
  - dout is frozen.
  - write=1 is ignored and sets wr_err.
  - ack=1: next cycle loaded=0, dout_valid=0, state=FILL. dout keeps its old contents; it is not zeroed.
  - write and ack in the same cycle: ack wins, the write is dropped, wr_err<=1.
- clear=1 (either state): next cycle loaded=0, dout_valid=0, state=FILL, wr_err=0, dout unchanged.
  - clear has priority over write and ack in the same cycle.
  - A load_done pulse scheduled for that edge is suppressed.
- ack during FILL: no effect.
- rst mid-operation returns everything to reset values immediately, independent of clk.
- dout is registered straight from the bank; there is no combinational path from din to dout.

Optional Feature:
Macro SIPO_AUTOINC_EN.
- Defined:
  - addr is ignored. An internal pointer wr_ptr (N_REG_BITS wide, reset 0) selects the word.
  - wr_ptr increments on each accepted write and wraps from N_REG-1 to 0.
  - wr_ptr resets to 0 on clear and on ack.
  - Completion occurs on the N_REG-th accepted write.
  - Rejected writes in HOLD do not advance wr_ptr.
- Not defined: addressed writes as described above; no wr_ptr register exists.

Decomposition:
- Shared package eddsa_io_pkg holds:
  - state encoding constants ST_FILL=1'b0 and ST_HOLD=1'b1
  - default R_DATA_WIDTH/N_REG values, shared with the read-out stage so both sides agree on word ordering
- No sub-module is needed. The bank plus control fits in a single module.
- Under SIPO_AUTOINC_EN, the pointer may optionally be split out as sipo_wr_ptr (a wrapping counter with clear).

Test Plan:
- Reset, then write words 0..7 with din=32'h1000_0000+i in order -> after the 8th write, next cycle dout_valid=1, load_done=1 for one cycle, dout[31:0]=32'h1000_0000, dout[255:224]=32'h1000_0007.
- Write addr 3 twice (32'hAAAA_AAAA then 32'h5555_5555), then write the rest -> word 3 = 32'h5555_5555, wr_err=0.
- In HOLD, write addr 0 with 32'hDEAD_BEEF -> dout unchanged, wr_err=1. Then ack -> dout_valid=0 and loaded=0 next cycle.
- Load 5 words, assert clear together with a write -> loaded=0, no word updated. Reload all 8 -> load_done fires once.
- Assert rst asynchronously in HOLD between clock edges -> all outputs 0 immediately.
- With SIPO_AUTOINC_EN, apply 8 writes with random addr -> words land at indices 0..7 in order. An ack followed by 8 more writes refills from index 0.

Source files
------------

// File: rtl/eddsa_io_pkg.sv
// Shared definitions for the EdDSA operand loader and result read-out stages.
// Word ordering defaults live here so both sides of the datapath agree.
package eddsa_io_pkg;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  localparam int DEF_R_DATA_WIDTH = 32;
  localparam int DEF_N_REG        = 8;

  typedef enum logic {
    S_FILL = ST_FILL,
    S_HOLD = ST_HOLD
  } sipo_state_t;

endpackage

// File: rtl/sipo_loader_if.sv
// Host-side write bus and core-side parallel operand bundle for sipo_loader.
// The host/bench uses the master modport, the loader uses the slave modport.
interface sipo_loader_if #(
  parameter int R_DATA_WIDTH = eddsa_io_pkg::DEF_R_DATA_WIDTH,
  parameter int N_REG        = eddsa_io_pkg::DEF_N_REG,
  parameter int N_REG_BITS   = $clog2(N_REG)
) ();

  logic                          write;
  logic [N_REG_BITS-1:0]         addr;
  logic [R_DATA_WIDTH-1:0]       din;
  logic                          clear;
  logic                          ack;
  logic [R_DATA_WIDTH*N_REG-1:0] dout;
  logic [N_REG-1:0]              loaded;
  logic                          dout_valid;
  logic                          load_done;
  logic                          wr_err;

  modport master (
    output write, addr, din, clear, ack,
    input  dout, loaded, dout_valid, load_done, wr_err
  );

  modport slave (
    input  write, addr, din, clear, ack,
    output dout, loaded, dout_valid, load_done, wr_err
  );

endinterface

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out operand loader: fills an N_REG-word bank, then holds it until ack.
// Define SIPO_AUTOINC_EN to replace addressed writes with an internal wrapping write pointer.
module sipo_loader
  import eddsa_io_pkg::*;
#(
  parameter int R_DATA_WIDTH = DEF_R_DATA_WIDTH,
  parameter int N_REG        = DEF_N_REG,
  parameter int N_REG_BITS   = $clog2(N_REG)
) (
  input logic          clk,
  input logic          rst,
  sipo_loader_if.slave bus
);

  sipo_state_t             r_state, w_state_next;
  logic [R_DATA_WIDTH-1:0] r_bank [N_REG];
  logic [N_REG-1:0]        r_loaded, w_loaded_next;
  logic                    r_load_done, w_load_done_next;
  logic                    r_wr_err, w_wr_err_next;
  logic                    w_we;
  logic [N_REG_BITS-1:0]   w_idx;
  logic                    w_idx_ok;
  logic [N_REG-1:0]        w_onehot;
  wire  [R_DATA_WIDTH*N_REG-1:0] w_dout;

`ifdef SIPO_AUTOINC_EN
  logic [N_REG_BITS-1:0] r_wr_ptr, w_wr_ptr_next;

  assign w_idx = r_wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_ptr <= '0;
    else     r_wr_ptr <= w_wr_ptr_next;
  end
`else
  assign w_idx = bus.addr;
`endif

  // Widened compare: only false when N_REG is not a power of two.
  assign w_idx_ok = ({1'b0, w_idx} < (N_REG_BITS+1)'(N_REG));
  assign w_onehot = N_REG'(1) << w_idx;

  always_comb begin
    w_state_next     = r_state;
    w_loaded_next    = r_loaded;
    w_load_done_next = 1'b0;
    w_wr_err_next    = r_wr_err;
    w_we             = 1'b0;
`ifdef SIPO_AUTOINC_EN
    w_wr_ptr_next    = r_wr_ptr;
`endif
    if (bus.clear) begin
      w_state_next  = S_FILL;
      w_loaded_next = '0;
      w_wr_err_next = 1'b0;
`ifdef SIPO_AUTOINC_EN
      w_wr_ptr_next = '0;
`endif
    end else begin
      case (r_state)
        S_FILL: begin
          if (bus.write) begin
            if (w_idx_ok) begin
              w_we          = 1'b1;
              w_loaded_next = r_loaded | w_onehot;
`ifdef SIPO_AUTOINC_EN
              w_wr_ptr_next = (r_wr_ptr == N_REG_BITS'(N_REG-1)) ? '0 : r_wr_ptr + 1'b1;
`endif
              if (&(r_loaded | w_onehot)) begin
                w_state_next     = S_HOLD;
                w_load_done_next = 1'b1;
              end
            end else begin
              w_wr_err_next = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.write) w_wr_err_next = 1'b1;
          if (bus.ack) begin
            w_state_next  = S_FILL;
            w_loaded_next = '0;
`ifdef SIPO_AUTOINC_EN
            w_wr_ptr_next = '0;
`endif
          end
        end
        default: w_state_next = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_loaded    <= '0;
      r_load_done <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_loaded    <= w_loaded_next;
      r_load_done <= w_load_done_next;
      r_wr_err    <= w_wr_err_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REG; i++) r_bank[i] <= '0;
    end else if (w_we) begin
      r_bank[w_idx] <= bus.din;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REG; gi++) begin : g_dout
      assign w_dout[R_DATA_WIDTH*gi +: R_DATA_WIDTH] = r_bank[gi];
    end
  endgenerate

  assign bus.dout       = w_dout;
  assign bus.loaded     = r_loaded;
  assign bus.dout_valid = (r_state == S_HOLD);
  assign bus.load_done  = r_load_done;
  assign bus.wr_err     = r_wr_err;

endmodule

// File: tb/tb_sipo_loader.sv
// Directed bench for sipo_loader: a cycle model feeds a scoreboard of completed operands.
// Works with or without SIPO_AUTOINC_EN; autoinc-only steps are guarded by that macro.
module tb_sipo_loader;
  import eddsa_io_pkg::*;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int AB = 3;
  localparam int DW = W * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_loader_if #(.R_DATA_WIDTH(W), .N_REG(N)) bus ();

  sipo_loader #(.R_DATA_WIDTH(W), .N_REG(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  m_bank [N];
  logic [N-1:0]  m_loaded;
  logic          m_hold, m_done, m_err;
  int            m_ptr;
  logic          prev_valid;
  logic [DW-1:0] sb_q [$];

  function automatic logic [DW-1:0] model_dout();
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = m_bank[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_bank[i] = '0;
    m_loaded   = '0;
    m_hold     = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
    m_ptr      = 0;
    prev_valid = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive inputs, advance the model, then check all outputs 1 time unit after the edge.
  task automatic cycle(input logic w, input int a, input logic [W-1:0] d,
                       input logic clr, input logic ak);
    int idx;
    bus.write = w;
    bus.addr  = AB'(a);
    bus.din   = d;
    bus.clear = clr;
    bus.ack   = ak;
    m_done = 1'b0;
    if (clr) begin
      m_loaded = '0; m_hold = 1'b0; m_err = 1'b0; m_ptr = 0;
    end else if (m_hold) begin
      if (w) m_err = 1'b1;
      if (ak) begin
        m_loaded = '0; m_hold = 1'b0; m_ptr = 0;
      end
    end else if (w) begin
`ifdef SIPO_AUTOINC_EN
      idx = m_ptr;
`else
      idx = a;
`endif
      if (idx < N) begin
        m_bank[idx] = d;
        m_loaded[idx] = 1'b1;
        m_ptr = (m_ptr == N - 1) ? 0 : m_ptr + 1;
        if (&m_loaded) begin
          m_hold = 1'b1;
          m_done = 1'b1;
          sb_q.push_back(model_dout());
        end
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    $display("t=%0t w=%0b a=%0d d=%08h clr=%0b ack=%0b -> valid=%0b done=%0b err=%0b loaded=%02h",
             $time, w, a, d, clr, ak, bus.dout_valid, bus.load_done, bus.wr_err, bus.loaded);
    chk("dout", bus.dout, model_dout());
    chk("loaded", DW'(bus.loaded), DW'(m_loaded));
    chk("dout_valid", DW'(bus.dout_valid), DW'(m_hold));
    chk("load_done", DW'(bus.load_done), DW'(m_done));
    chk("wr_err", DW'(bus.wr_err), DW'(m_err));
    if (bus.dout_valid && !prev_valid) begin
      chk("sb_pending", DW'(sb_q.size()), DW'(1));
      if (sb_q.size() > 0) chk("sb_operand", bus.dout, sb_q.pop_front());
    end
    prev_valid = bus.dout_valid;
  endtask

  task automatic idle();
    cycle(1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    cycle(1'b1, a, d, 1'b0, 1'b0);
  endtask

  int done_cnt;

  initial begin
    bus.write = 1'b0; bus.addr = '0; bus.din = '0; bus.clear = 1'b0; bus.ack = 1'b0;
    model_reset();
    rst = 1'b1;
    #12;
    chk("rst_dout", bus.dout, '0);
    chk("rst_valid", DW'(bus.dout_valid), DW'(0));
    rst = 1'b0;
    idle();

    // Sequential fill 0..7
    for (int i = 0; i < N; i++) wr(i, 32'h1000_0000 + i);
    chk("t1_valid", DW'(bus.dout_valid), DW'(1));
    chk("t1_done", DW'(bus.load_done), DW'(1));
    chk("t1_w0", DW'(bus.dout[31:0]), DW'(32'h1000_0000));
    chk("t1_w7", DW'(bus.dout[255:224]), DW'(32'h1000_0007));
    idle();
    chk("t1_done_pulse", DW'(bus.load_done), DW'(0));

    // Ack in HOLD, then ack during FILL has no effect
    cycle(1'b0, 0, '0, 1'b0, 1'b1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1);

    // Overwrite word 3 before completing
    wr(3, 32'hAAAA_AAAA);
    wr(3, 32'h5555_5555);
    for (int i = 0; i < N; i++) if (i != 3) wr(i, 32'h2000_0000 + i);
`ifndef SIPO_AUTOINC_EN
    chk("t2_word3", DW'(bus.dout[127:96]), DW'(32'h5555_5555));
    chk("t2_no_err", DW'(bus.wr_err), DW'(0));
`endif
    idle();

    // Rejected write in HOLD, then ack
    wr(0, 32'hDEAD_BEEF);
    chk("t3_err", DW'(bus.wr_err), DW'(m_err));
    cycle(1'b0, 0, '0, 1'b0, 1'b1);
    chk("t3_ack_valid", DW'(bus.dout_valid), DW'(0));
    chk("t3_ack_loaded", DW'(bus.loaded), DW'(0));

    // Clear together with a write after 5 words, then full reload
    for (int i = 0; i < 5; i++) wr(i, 32'h3000_0000 + i);
    cycle(1'b1, 5, 32'hBAD0_0005, 1'b1, 1'b0);
    chk("t4_cleared", DW'(bus.loaded), DW'(0));
    done_cnt = 0;
    for (int i = 0; i < N; i++) begin
      wr(i, 32'h4000_0000 + i);
      if (bus.load_done) done_cnt++;
    end
    idle();
    if (bus.load_done) done_cnt++;
    chk("t4_done_once", DW'(done_cnt), DW'(1));

    // Write and ack together in HOLD: ack wins, write flagged
    cycle(1'b1, 2, 32'h1234_5678, 1'b0, 1'b1);

    // Clear on the completing write suppresses load_done
    for (int i = 0; i < N - 1; i++) wr(i, 32'h5000_0000 + i);
    cycle(1'b1, N - 1, 32'h5000_0007, 1'b1, 1'b0);

`ifdef SIPO_AUTOINC_EN
    // Random addr is ignored; words land in order, refill after ack restarts at 0
    for (int i = 0; i < N; i++) wr($urandom_range(0, N - 1), 32'h6000_0000 + i);
    chk("ai_w0", DW'(bus.dout[31:0]), DW'(32'h6000_0000));
    chk("ai_w7", DW'(bus.dout[255:224]), DW'(32'h6000_0007));
    cycle(1'b0, 0, '0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) wr($urandom_range(0, N - 1), 32'h7000_0000 + i);
    chk("ai_refill_w0", DW'(bus.dout[31:0]), DW'(32'h7000_0000));
`else
    for (int i = N - 1; i >= 0; i--) wr(i, 32'h6000_0000 + i);
`endif

    // Asynchronous reset between edges while in HOLD
    chk("t5_hold", DW'(bus.dout_valid), DW'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("t5_dout", bus.dout, '0);
    chk("t5_loaded", DW'(bus.loaded), DW'(0));
    chk("t5_valid", DW'(bus.dout_valid), DW'(0));
    chk("t5_err", DW'(bus.wr_err), DW'(0));
    model_reset();
    #2;
    rst = 1'b0;
    idle();
    wr(1, 32'h0BAD_CAFE);

    chk("sb_drained", DW'(sb_q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
